// File: rtl/booth_seq_mul_if.sv
// Handshake and data bundle for the sequential radix-4 Booth multiplier.
// The master drives a request; the slave (the multiplier) returns status and the product.
interface booth_seq_mul_if #(
  parameter int N = 8
);
  logic           start;
  logic           tc;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, tc, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, tc, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/booth_seq_mul.sv
// Multi-cycle radix-4 Booth multiplier retiring one Booth digit per clock into a 2N-bit
// accumulator; unsigned or two's-complement operands chosen per operation.
module booth_seq_mul #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst,
  booth_seq_mul_if.slave  bus
);
  localparam int JW = $clog2(N / 2 + 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [2*N-1:0]  aExt_q;
  logic [N+2:0]    bExt_q;
  logic [2*N-1:0]  acc_q;
  logic [JW-1:0]   j_q;
  logic [JW-1:0]   lastJ_q;
  logic            busy_q;
  logic            done_q;
  logic [2*N-1:0]  product_q;

  logic [2:0]      trip;
  logic [2*N-1:0]  twoA;
  logic [2*N-1:0]  pp;
  logic [2*N-1:0]  acc_d;

  // bExt_q bit 0 is the implicit B[-1], so digit j's triplet starts at bit 2j.
  always_comb begin
    trip  = bExt_q[{j_q, 1'b0} +: 3];
    twoA  = {aExt_q[2*N-2:0], 1'b0};
    pp    = '0;
    case (trip)
      3'b001, 3'b010: pp = aExt_q;
      3'b011:         pp = twoA;
      3'b100:         pp = -twoA;
      3'b101, 3'b110: pp = -aExt_q;
      default:        pp = '0;
    endcase
    acc_d = acc_q + (pp << {j_q, 1'b0});
  end

  // Signed mode skips the top digit, which would be pure sign and add nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      aExt_q    <= '0;
      bExt_q    <= '0;
      acc_q     <= '0;
      j_q       <= '0;
      lastJ_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            aExt_q  <= {{N{bus.tc & bus.a[N-1]}}, bus.a};
            bExt_q  <= {{2{bus.tc & bus.b[N-1]}}, bus.b, 1'b0};
            lastJ_q <= bus.tc ? JW'(N / 2 - 1) : JW'(N / 2);
            acc_q   <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          j_q   <= j_q + JW'(1);
          if (j_q == lastJ_q) begin
            product_q <= acc_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed self-checking bench for booth_seq_mul (N=8): timing, handshake, reset and
// a short run of random operands against a bench-side multiply.
module tb_booth_seq_mul;
  localparam int N = 8;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  booth_seq_mul_if #(.N(N)) bus();

  booth_seq_mul #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Pulses start for one cycle; returns at the falling edge of the first busy cycle.
  task automatic applyStimulus(input logic [N-1:0] aV, input logic [N-1:0] bV,
                               input logic tcV);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = aV;
    bus.b     = bV;
    bus.tc    = tcV;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(output int busyCycles, output int seen);
    busyCycles = 0;
    seen       = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1;
        break;
      end
      if (bus.busy === 1'b1) busyCycles++;
      @(negedge clk);
    end
  endtask

  task automatic runOp(input string tag, input logic [N-1:0] aV, input logic [N-1:0] bV,
                       input logic tcV, input logic [2*N-1:0] expProd, input int expBusy);
    int busyCycles;
    int seen;
    applyStimulus(aV, bV, tcV);
    waitDone(busyCycles, seen);
    checkOutput({tag, ".doneSeen"}, 32'(seen), 32'd1);
    checkOutput({tag, ".busyCycles"}, 32'(busyCycles), 32'(expBusy));
    checkOutput({tag, ".product"}, 32'(bus.product), 32'(expProd));
    checkOutput({tag, ".busyInDone"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput({tag, ".doneAfter"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int busyCycles;
    int seen;
    int gap;
    int doneCount;
    logic [N-1:0]   ra;
    logic [N-1:0]   rb;
    logic           rtc;
    logic [2*N-1:0] ea;
    logic [2*N-1:0] eb;
    logic [2*N-1:0] golden;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.tc    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.busy", 32'(bus.busy), 32'd0);
    checkOutput("reset.done", 32'(bus.done), 32'd0);
    checkOutput("reset.product", 32'(bus.product), 32'd0);

    runOp("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 5);
    runOp("sMinxMin", 8'h80, 8'h80, 1'b1, 16'h4000, 4);
    runOp("sNeg1x127", 8'hFF, 8'h7F, 1'b1, 16'hFF81, 4);
    runOp("u0xA5", 8'h00, 8'hA5, 1'b0, 16'h0000, 5);
    runOp("u1x80", 8'h01, 8'h80, 1'b0, 16'h0080, 5);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold.product", 32'(bus.product), 32'h0080);
      checkOutput("hold.done", 32'(bus.done), 32'd0);
    end

    // A start raised mid-operation with new operands must be dropped entirely.
    applyStimulus(8'd10, 8'd20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.tc    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(busyCycles, seen);
    checkOutput("ignore.doneSeen", 32'(seen), 32'd1);
    checkOutput("ignore.busyRest", 32'(busyCycles), 32'd2);
    checkOutput("ignore.product", 32'(bus.product), 32'd200);
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneCount++;
    end
    checkOutput("ignore.extraDone", 32'(doneCount), 32'd0);
    checkOutput("ignore.idleBusy", 32'(bus.busy), 32'd0);

    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd3;
    bus.b     = 8'd7;
    bus.tc    = 1'b0;
    @(negedge clk);
    waitDone(busyCycles, seen);
    checkOutput("b2b.first.doneSeen", 32'(seen), 32'd1);
    checkOutput("b2b.first.busyCycles", 32'(busyCycles), 32'd5);
    checkOutput("b2b.first.product", 32'(bus.product), 32'd21);
    bus.a = 8'd200;
    bus.b = 8'd13;
    gap   = 0;
    seen  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      gap++;
      if (gap == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checkOutput("b2b.second.doneSeen", 32'(seen), 32'd1);
    checkOutput("b2b.gap", 32'(gap), 32'd6);
    checkOutput("b2b.second.product", 32'(bus.product), 32'd2600);
    bus.start = 1'b0;
    @(negedge clk);

    // Reset lands in the second busy cycle of an operation that is then abandoned.
    applyStimulus(8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midReset.busy", 32'(bus.busy), 32'd0);
    checkOutput("midReset.done", 32'(bus.done), 32'd0);
    checkOutput("midReset.product", 32'(bus.product), 32'd0);
    doneCount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneCount++;
    end
    checkOutput("midReset.noDone", 32'(doneCount), 32'd0);
    runOp("u12x12", 8'd12, 8'd12, 1'b0, 16'd144, 5);

    for (int k = 0; k < 40; k++) begin
      ra     = N'($urandom);
      rb     = N'($urandom);
      rtc    = 1'($urandom_range(0, 1));
      ea     = rtc ? {{N{ra[N-1]}}, ra} : {{N{1'b0}}, ra};
      eb     = rtc ? {{N{rb[N-1]}}, rb} : {{N{1'b0}}, rb};
      golden = ea * eb;
      runOp($sformatf("rand%0d", k), ra, rb, rtc, golden, rtc ? 4 : 5);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
